// File: rtl/bcd_meas_pkg.sv
// rtl/bcd_meas_pkg.sv - shared types and constants for the gated BCD measurement controller
// Contents: measurement FSM state enum, BCD result width, saturated result value.
package bcd_meas_pkg;

    localparam int BCD_W = 12;

    // Result reported when the counter chain overflowed during the gate.
    localparam logic [BCD_W-1:0] BCD_SAT = 12'h999;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH
    } meas_state_t;

endpackage

// File: rtl/bcd_meas_ctrl_if.sv
// rtl/bcd_meas_ctrl_if.sv - bus between the measurement controller and the BCD counter chain
// Signals:
//   cnt_q     12  BCD count {hundreds, tens, units} from the counter chain
//   cnt_cout   1  carry-out of the chain (count 999 with carry-in high)
//   cnt_cin    1  carry-in drive to the chain
//   cnt_clr_n  1  counter clear, active-low
// Modports: master = controller side, slave = counter chain side.
interface bcd_meas_ctrl_if;
    import bcd_meas_pkg::*;

    logic [BCD_W-1:0] cnt_q;
    logic             cnt_cout;
    logic             cnt_cin;
    logic             cnt_clr_n;

    modport master (
        output cnt_cin,
        output cnt_clr_n,
        input  cnt_q,
        input  cnt_cout
    );

    modport slave (
        input  cnt_cin,
        input  cnt_clr_n,
        output cnt_q,
        output cnt_cout
    );

endinterface

// File: rtl/bcd_gate_timer.sv
// rtl/bcd_gate_timer.sv - loadable gate-window up-counter with terminal count
// Ports:
//   Clk, Rst_n  clock, synchronous active-low reset
//   load        reload the count with 0 (has priority over en)
//   en          advance the count by one
//   tc          high while the count equals GATE_CYCLES-1
module bcd_gate_timer #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int TMR_W       = 26
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(GATE_CYCLES - 1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/bcd_meas_ctrl.sv
// rtl/bcd_meas_ctrl.sv - gated-measurement controller for a 3-digit cascaded BCD counter
// Optional feature macro: BCD_MEAS_CTRL_HOLD_EN (adds the hold input that pauses the gate).
// Ports:
//   Clk, Rst_n    clock, synchronous active-low reset
//   start         begin a measurement (sampled only in IDLE)
//   cont          re-arm after each result instead of returning to IDLE (sampled in LATCH)
//   evt_in        single-cycle event pulse, already synchronized
//   hold          (macro only) pause the gate window while high
//   cnt           counter-chain bus (master side): cnt_q, cnt_cout in; cnt_cin, cnt_clr_n out
//   result        latched BCD result, 12'h999 when the count overflowed
//   result_valid  one-cycle strobe coincident with a result update
//   overflow      overflow flag belonging to the last latched result
//   busy          high in every state except IDLE
module bcd_meas_ctrl
    import bcd_meas_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int TMR_W       = 26
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  evt_in,
`ifdef BCD_MEAS_CTRL_HOLD_EN
    input  logic                  hold,
`endif
    bcd_meas_ctrl_if.master       cnt,
    output logic [BCD_W-1:0]      result,
    output logic                  result_valid,
    output logic                  overflow,
    output logic                  busy
);

    meas_state_t state;
    logic        ovf_acc;
    logic        clr_n_q;
    logic        hold_act;
    logic        gate_open;
    logic        timer_tc;

`ifdef BCD_MEAS_CTRL_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // The gate is open only in GATE and not while paused; both the event
    // pass-through and the timer advance are tied to this single term so a
    // paused cycle neither counts events nor consumes window time.
    assign gate_open   = (state == GATE) && !hold_act;
    assign cnt.cnt_cin = evt_in & gate_open;
    assign cnt.cnt_clr_n = clr_n_q;

    bcd_gate_timer #(
        .GATE_CYCLES (GATE_CYCLES),
        .TMR_W       (TMR_W)
    ) u_gate_timer (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .load  (state == CLEAR),
        .en    (gate_open),
        .tc    (timer_tc)
    );

    // Outputs are registered on the transition into the state that owns them:
    // the clear strobe on entry to CLEAR, the result/strobe on entry to LATCH
    // (the SETTLE cycle lets the counter's q absorb the final gated event).
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state        <= IDLE;
            ovf_acc      <= 1'b0;
            clr_n_q      <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            clr_n_q      <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        clr_n_q <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    ovf_acc <= 1'b0;
                    state   <= GATE;
                end
                GATE: begin
                    if (cnt.cnt_cout) begin
                        ovf_acc <= 1'b1;
                    end
                    if (gate_open && timer_tc) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    result       <= ovf_acc ? BCD_SAT : cnt.cnt_q;
                    overflow     <= ovf_acc;
                    result_valid <= 1'b1;
                    state        <= LATCH;
                end
                LATCH: begin
                    if (cont) begin
                        state   <= CLEAR;
                        clr_n_q <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_meas_ctrl.sv
// tb/tb_bcd_meas_ctrl.sv - self-checking bench for bcd_meas_ctrl
module tb_bcd_meas_ctrl;

    localparam int GC   = 10;
    localparam int GC_B = 1200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0, cont = 1'b0, evt_in = 1'b0, hold = 1'b0;
    logic start_b = 1'b0, evt_b = 1'b0;
    logic [11:0] result, result_b;
    logic result_valid, overflow, busy;
    logic result_valid_b, overflow_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_meas_ctrl_if bus_a ();
    bcd_meas_ctrl_if bus_b ();

    bcd_meas_ctrl #(.GATE_CYCLES(GC), .TMR_W(4)) u_dut (
        .Clk          (clk),
        .Rst_n        (rst_n),
        .start        (start),
        .cont         (cont),
        .evt_in       (evt_in),
`ifdef BCD_MEAS_CTRL_HOLD_EN
        .hold         (hold),
`endif
        .cnt          (bus_a),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow),
        .busy         (busy)
    );

    bcd_meas_ctrl #(.GATE_CYCLES(GC_B), .TMR_W(11)) u_dut_ovf (
        .Clk          (clk),
        .Rst_n        (rst_n),
        .start        (start_b),
        .cont         (1'b0),
        .evt_in       (evt_b),
`ifdef BCD_MEAS_CTRL_HOLD_EN
        .hold         (1'b0),
`endif
        .cnt          (bus_b),
        .result       (result_b),
        .result_valid (result_valid_b),
        .overflow     (overflow_b),
        .busy         (busy_b)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Behavioural 3-digit BCD counters kept as plain integers.
    int cnt_a = 0, cnt_b = 0;
    always @(posedge clk) begin
        if (!(bus_a.cnt_clr_n && rst_n)) cnt_a <= 0;
        else if (bus_a.cnt_cin)          cnt_a <= (cnt_a + 1) % 1000;
        if (!(bus_b.cnt_clr_n && rst_n)) cnt_b <= 0;
        else if (bus_b.cnt_cin)          cnt_b <= (cnt_b + 1) % 1000;
    end
    assign bus_a.cnt_q    = to_bcd(cnt_a);
    assign bus_a.cnt_cout = bus_a.cnt_cin && (cnt_a == 999);
    assign bus_b.cnt_q    = to_bcd(cnt_b);
    assign bus_b.cnt_cout = bus_b.cnt_cin && (cnt_b == 999);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Cycle k counts from the start edge (k=1 is CLEAR). The gate opens at k=2
    // and stays open for GC non-held cycles; held cycles extend the window.
    function automatic logic [47:0] gate_open(input int h_at, input int h_len);
        logic [47:0] open = '0;
        int rem = GC;
        for (int k = 2; k < 48; k++) begin
            if (rem > 0 && !(k >= h_at && k < h_at + h_len)) begin
                open[k] = 1'b1;
                rem--;
            end else if (rem > 0) begin
                open[k] = 1'b0;
            end
        end
        return open;
    endfunction

    function automatic int model_lat(input logic [47:0] open);
        int last = 0;
        for (int k = 0; k < 48; k++) if (open[k]) last = k;
        return last + 2;
    endfunction

    task automatic run_meas(input string name, input logic [47:0] mask, input int start_at,
                            input int h_at, input int h_len,
                            input logic [11:0] exp_res, input int exp_lat);
        logic [47:0] open, cin_obs, clr_obs, busy_obs, exp_busy;
        int got_lat = 0;
        logic [11:0] got_res = '0;
        logic got_ovf = 1'b0;
        open = gate_open(h_at, h_len);
        cin_obs = '0; clr_obs = '0; busy_obs = '0;
        @(negedge clk);
        start = 1'b1; evt_in = 1'b0; hold = 1'b0;
        for (int k = 1; k <= exp_lat + 1 && k < 48; k++) begin
            @(negedge clk);
            busy_obs[k] = busy;
            clr_obs[k]  = ~bus_a.cnt_clr_n;
            if (result_valid) begin
                if (got_lat == 0) begin
                    got_lat = k; got_res = result; got_ovf = overflow;
                end else begin
                    got_lat = -1;
                end
            end
            start  = (k == start_at);
            evt_in = mask[k];
            hold   = (h_len > 0 && k >= h_at && k < h_at + h_len);
            #1 cin_obs[k] = bus_a.cnt_cin;
        end
        start = 1'b0; evt_in = 1'b0; hold = 1'b0;
        exp_busy = ((48'h1 << (exp_lat + 1)) - 48'h1) & ~48'h1;
        check({name, "/latency"}, 64'(got_lat), 64'(exp_lat));
        check({name, "/result"}, 64'(got_res), 64'(exp_res));
        check({name, "/overflow"}, 64'(got_ovf), 64'(0));
        check({name, "/cin"}, 64'(cin_obs), 64'(mask & open));
        check({name, "/clr_n"}, 64'(clr_obs), 64'h2);
        check({name, "/busy"}, 64'(busy_obs), 64'(exp_busy));
    endtask

    task automatic run_big(input string name, input int nev, input logic [11:0] exp_res,
                           input logic exp_ovf);
        int got_lat = 0;
        logic [11:0] got_res = '0;
        logic got_ovf = 1'b0, seen = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        for (int k = 1; k <= 1300; k++) begin
            @(negedge clk);
            if (result_valid_b) begin
                got_lat = k; got_res = result_b; got_ovf = overflow_b;
            end
            start_b = 1'b0;
            evt_b   = (k >= 2 && k < 2 + nev);
            #1 if (bus_b.cnt_cout) seen = 1'b1;
            if (got_lat != 0) break;
        end
        evt_b = 1'b0;
        check({name, "/latency"}, 64'(got_lat), 64'(GC_B + 3));
        check({name, "/result"}, 64'(got_res), 64'(exp_res));
        check({name, "/overflow"}, 64'(got_ovf), 64'(exp_ovf));
        check({name, "/cout_seen"}, 64'(seen), 64'(exp_ovf));
    endtask

    typedef struct {
        string       name;
        logic [47:0] mask;
        int          start_at;
        logic [11:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"basic",       48'hB6C,    0,  12'h007, 13};
        vecs[1] = '{"boundary",    48'h1806,   0,  12'h002, 13};
        vecs[2] = '{"no_events",   48'h0,      0,  12'h000, 13};
        vecs[3] = '{"all_events",  {48{1'b1}}, 0,  12'h010, 13};
        vecs[4] = '{"start_gate",  48'hD0,     5,  12'h003, 13};
        vecs[5] = '{"start_latch", 48'hC3C,    13, 12'h006, 13};

        // Reset values, with an event present that must not leak to cin.
        evt_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst/result", 64'(result), 64'h0);
        check("rst/result_valid", 64'(result_valid), 64'h0);
        check("rst/overflow", 64'(overflow), 64'h0);
        check("rst/busy", 64'(busy), 64'h0);
        check("rst/cnt_cin", 64'(bus_a.cnt_cin), 64'h0);
        check("rst/cnt_clr_n", 64'(bus_a.cnt_clr_n), 64'h1);
        evt_in = 1'b0;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_meas(vecs[i].name, vecs[i].mask, vecs[i].start_at, 0, 0,
                     vecs[i].exp_res, vecs[i].exp_lat);

        // Randomized windows against the gate-window model.
        for (int i = 0; i < 16; i++) begin
            logic [47:0] m, open;
            int h_at = 0, h_len = 0;
            m = {16'($urandom), $urandom};
`ifdef BCD_MEAS_CTRL_HOLD_EN
            h_len = $urandom_range(0, 4);
            h_at  = $urandom_range(2, 12);
`endif
            open = gate_open(h_at, h_len);
            run_meas($sformatf("rand%0d", i), m, 0, h_at, h_len,
                     to_bcd($countones(m & open)), model_lat(open));
        end

`ifdef BCD_MEAS_CTRL_HOLD_EN
        run_meas("hold", {48{1'b1}}, 0, 5, 4, 12'h010, 17);
`endif

        // Continuous mode: 3 windows of 5 gated events, with extra events in
        // CLEAR/SETTLE/LATCH; cont dropped during the third gate.
        begin
            logic [63:0] rv_obs = '0, clr_obs = '0;
            logic [11:0] res_seen[3];
            int n_rv = 0;
            @(negedge clk);
            cont = 1'b1; start = 1'b1;
            for (int k = 1; k <= 41; k++) begin
                @(negedge clk);
                rv_obs[k]  = result_valid;
                clr_obs[k] = ~bus_a.cnt_clr_n;
                if (result_valid && n_rv < 3) begin
                    res_seen[n_rv] = result; n_rv++;
                end
                if (k == 40) check("cont/busy_after", 64'(busy), 64'h0);
                start  = 1'b0;
                cont   = (k < 30);
                evt_in = ((k % 13) inside {0, 1, 2, 4, 6, 8, 10, 12});
            end
            evt_in = 1'b0;
            check("cont/strobes", rv_obs, (64'h1 << 13) | (64'h1 << 26) | (64'h1 << 39));
            check("cont/clears", clr_obs, (64'h1 << 1) | (64'h1 << 14) | (64'h1 << 27));
            check("cont/n_results", 64'(n_rv), 64'd3);
            for (int w = 0; w < 3 && w < n_rv; w++)
                check($sformatf("cont/result%0d", w), 64'(res_seen[w]), 64'h005);
        end

        // Reset in the middle of a gate discards the count and the old result.
        run_meas("pre_reset", 48'h3C, 0, 0, 0, 12'h004, 13);
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0; evt_in = 1'b1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst/busy", 64'(busy), 64'h0);
        check("midrst/result", 64'(result), 64'h0);
        check("midrst/result_valid", 64'(result_valid), 64'h0);
        check("midrst/overflow", 64'(overflow), 64'h0);
        check("midrst/cnt_cin", 64'(bus_a.cnt_cin), 64'h0);
        check("midrst/cnt_clr_n", 64'(bus_a.cnt_clr_n), 64'h1);
        rst_n = 1'b1; evt_in = 1'b0;
        run_meas("after_reset", 48'h38, 0, 0, 0, 12'h003, 13);

        // Overflow on the long-gate instance, then a clean run.
        run_big("ovf", 1300, 12'h999, 1'b1);
        run_big("ovf_clean", 3, 12'h003, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
